// File: rtl/shift_link_pkg.sv
// Shared types and width constants for the shift-register serializer link.
// Width macros may be overridden on the command line; the defaults describe a 16-bit word over a 4-bit link.
`ifndef SHIFT_FROM
`define SHIFT_FROM 16
`endif
`ifndef SHIFT_LOGFROM
`define SHIFT_LOGFROM 4
`endif
`ifndef SHIFT_TO
`define SHIFT_TO 4
`endif

package shift_link_pkg;
    typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} deser_state_e;

    localparam int FROM     = `SHIFT_FROM;
    localparam int LOG2FROM = `SHIFT_LOGFROM;
    localparam int TO       = `SHIFT_TO;
    localparam int BEATS    = FROM / TO;
endpackage

// File: rtl/shift_frame_tracker.sv
// Frame alignment FSM and beat counter for the deserializer.
// Classifies each valid beat as shift, word completion or framing error.
module shift_frame_tracker
    import shift_link_pkg::*;
#(
    parameter int N     = BEATS,
    parameter int CNT_W = LOG2FROM + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    input  logic last_i,
    output logic shift_en,
    output logic word_done,
    output logic frame_err,
    output logic aligned
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    deser_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and beat-count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state decode; idle cycles leave everything untouched
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_en  = 1'b0;
        word_done = 1'b0;
        frame_err = 1'b0;
        if (valid_i) begin
            case (state_q)
                HUNT: begin
                    if (last_i) begin
                        state_d = SYNC;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = HUNT;
                    end
                end
                SYNC: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (last_i) begin
                            word_done = 1'b1;
                        end else begin
                            // Overlong frame: alignment is no longer trusted
                            frame_err = 1'b1;
                            state_d   = HUNT;
                        end
                    end else begin
                        if (last_i) begin
                            frame_err = 1'b1;
                            cnt_d     = {CNT_W{1'b0}};
                        end else begin
                            shift_en = 1'b1;
                            cnt_d    = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign aligned = (state_q == SYNC);

endmodule

// File: rtl/shift_deserializer.sv
// Receive side of the shift-register link: rebuilds FROM-bit words from TO-bit beats,
// MS chunk first, and presents each completed word with a one-cycle valid_o pulse.
module shift_deserializer
    import shift_link_pkg::*;
#(
    parameter int FROM     = shift_link_pkg::FROM,
    parameter int LOG2FROM = shift_link_pkg::LOG2FROM,
    parameter int TO       = shift_link_pkg::TO
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [TO-1:0]   data_i,
    input  logic            valid_i,
    input  logic            last_i,
    output logic [FROM-1:0] data_o,
    output logic            valid_o,
    output logic            aligned_o,
    output logic            err_o
);

    localparam int N = FROM / TO;

    logic            shift_en_s, word_done_s, frame_err_s, aligned_s;
    logic [FROM-1:0] shift_q, shift_d;
    logic [FROM-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    shift_frame_tracker #(
        .N     (N),
        .CNT_W (LOG2FROM + 1)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .shift_en  (shift_en_s),
        .word_done (word_done_s),
        .frame_err (frame_err_s),
        .aligned   (aligned_s)
    );

    // Shift register and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= {FROM{1'b0}};
            data_q  <= {FROM{1'b0}};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // The closing beat never passes through the shift register; it is merged directly as the LS chunk
    always_comb begin
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = word_done_s;
        err_d   = frame_err_s;
        if (shift_en_s) begin
            shift_d = {shift_q[FROM-TO-1:0], data_i};
        end else begin
            shift_d = shift_q;
        end
        if (word_done_s) begin
            data_d = {shift_q[FROM-TO-1:0], data_i};
        end else begin
            data_d = data_q;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign err_o     = err_q;
    assign aligned_o = aligned_s;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed testbench for shift_deserializer with FROM=16, TO=4 (four beats per word).
module tb_shift_deserializer;

    logic        clk;
    logic        reset;
    logic [3:0]  data_i;
    logic        valid_i;
    logic        last_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        aligned_o;
    logic        err_o;

    int tests_run;
    int tests_failed;

    shift_deserializer #(
        .FROM     (16),
        .LOG2FROM (4),
        .TO       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .aligned_o (aligned_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one valid beat, then check the pulses registered from it
    task automatic beat(input string tag, input logic [3:0] d, input logic l,
                        input logic exp_valid, input logic exp_err);
        @(negedge clk);
        data_i  = d;
        valid_i = 1'b1;
        last_i  = l;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(valid_o), 32'(exp_valid));
        check({tag, ".err"}, 32'(err_o), 32'(exp_err));
    endtask

    // Idle cycle with junk on the data/last lines
    task automatic idle(input string tag);
        @(negedge clk);
        data_i  = 4'($urandom_range(0, 15));
        valid_i = 1'b0;
        last_i  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(valid_o), 32'd0);
        check({tag, ".err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b0;
        data_i  = 4'h0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.data", 32'(data_o), 32'h0);
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.aligned", 32'(aligned_o), 32'd0);
        check("rst.err", 32'(err_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: dummy beat acquires alignment, then ABCD
        beat("t1.dummy", 4'h0, 1'b1, 1'b0, 1'b0);
        check("t1.aligned", 32'(aligned_o), 32'd1);
        beat("t1.a", 4'hA, 1'b0, 1'b0, 1'b0);
        beat("t1.b", 4'hB, 1'b0, 1'b0, 1'b0);
        beat("t1.c", 4'hC, 1'b0, 1'b0, 1'b0);
        check("t1.data_before", 32'(data_o), 32'h0);
        beat("t1.d", 4'hD, 1'b1, 1'b1, 1'b0);
        check("t1.data", 32'(data_o), 32'hABCD);

        // 2: back-to-back words
        beat("t2.1", 4'h1, 1'b0, 1'b0, 1'b0);
        check("t2.hold", 32'(data_o), 32'hABCD);
        beat("t2.2", 4'h2, 1'b0, 1'b0, 1'b0);
        beat("t2.3", 4'h3, 1'b0, 1'b0, 1'b0);
        beat("t2.4", 4'h4, 1'b1, 1'b1, 1'b0);
        check("t2.data0", 32'(data_o), 32'h1234);
        beat("t2.f", 4'hF, 1'b0, 1'b0, 1'b0);
        beat("t2.e", 4'hE, 1'b0, 1'b0, 1'b0);
        beat("t2.d", 4'hD, 1'b0, 1'b0, 1'b0);
        beat("t2.c", 4'hC, 1'b1, 1'b1, 1'b0);
        check("t2.data1", 32'(data_o), 32'hFEDC);

        // 3: short frame, then a good one
        beat("t3.5", 4'h5, 1'b0, 1'b0, 1'b0);
        beat("t3.6", 4'h6, 1'b0, 1'b0, 1'b0);
        beat("t3.7", 4'h7, 1'b1, 1'b0, 1'b1);
        check("t3.data_kept", 32'(data_o), 32'hFEDC);
        check("t3.aligned", 32'(aligned_o), 32'd1);
        beat("t3.8", 4'h8, 1'b0, 1'b0, 1'b0);
        beat("t3.9", 4'h9, 1'b0, 1'b0, 1'b0);
        beat("t3.a", 4'hA, 1'b0, 1'b0, 1'b0);
        beat("t3.b", 4'hB, 1'b1, 1'b1, 1'b0);
        check("t3.data", 32'(data_o), 32'h89AB);

        // 4: long frame drops to HUNT; needs a delimiter and a full frame to recover
        beat("t4.1", 4'h1, 1'b0, 1'b0, 1'b0);
        beat("t4.2", 4'h2, 1'b0, 1'b0, 1'b0);
        beat("t4.3", 4'h3, 1'b0, 1'b0, 1'b0);
        beat("t4.4", 4'h4, 1'b0, 1'b0, 1'b1);
        check("t4.hunt", 32'(aligned_o), 32'd0);
        check("t4.data_kept", 32'(data_o), 32'h89AB);
        beat("t4.5", 4'h5, 1'b0, 1'b0, 1'b0);
        check("t4.still_hunt", 32'(aligned_o), 32'd0);
        beat("t4.delim", 4'h9, 1'b1, 1'b0, 1'b0);
        check("t4.resync", 32'(aligned_o), 32'd1);
        beat("t4.w2", 4'h2, 1'b0, 1'b0, 1'b0);
        beat("t4.w4", 4'h4, 1'b0, 1'b0, 1'b0);
        beat("t4.w6", 4'h6, 1'b0, 1'b0, 1'b0);
        beat("t4.w8", 4'h8, 1'b1, 1'b1, 1'b0);
        check("t4.data", 32'(data_o), 32'h2468);

        // 5: idle cycles between every beat
        idle("t5.i0");
        beat("t5.c", 4'hC, 1'b0, 1'b0, 1'b0);
        idle("t5.i1");
        idle("t5.i2");
        beat("t5.0", 4'h0, 1'b0, 1'b0, 1'b0);
        idle("t5.i3");
        beat("t5.d", 4'hD, 1'b0, 1'b0, 1'b0);
        idle("t5.i4");
        beat("t5.e", 4'hE, 1'b1, 1'b1, 1'b0);
        idle("t5.i5");
        check("t5.data", 32'(data_o), 32'hC0DE);

        // 6: async reset mid-frame, re-acquire via HUNT
        beat("t6.1", 4'h1, 1'b0, 1'b0, 1'b0);
        beat("t6.2", 4'h2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6.rst_data", 32'(data_o), 32'h0);
        check("t6.rst_aligned", 32'(aligned_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        beat("t6.3", 4'h3, 1'b0, 1'b0, 1'b0);
        check("t6.hunt", 32'(aligned_o), 32'd0);
        beat("t6.delim", 4'h4, 1'b1, 1'b0, 1'b0);
        beat("t6.5", 4'h5, 1'b0, 1'b0, 1'b0);
        beat("t6.a", 4'hA, 1'b0, 1'b0, 1'b0);
        beat("t6.5b", 4'h5, 1'b0, 1'b0, 1'b0);
        beat("t6.ab", 4'hA, 1'b1, 1'b1, 1'b0);
        check("t6.data", 32'(data_o), 32'h5A5A);
        idle("t6.tail");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
